// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants, bus widths and FSM encoding for the fetch-stage controller.
package if_fetch_ctrl_pkg;

  localparam int unsigned RegW      = 32;
  localparam int unsigned JbrBusW   = 33;
  localparam int unsigned ExcBusW   = 33;
  localparam logic [31:0] LoongPcStartAddr = 32'h1c000000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } fetch_state_e;

  function automatic logic [RegW-1:0] next_seq_pc(input logic [RegW-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_redirect_arb.sv
// Priority select between the exception/ertn bus and the branch/jump bus.
module if_redirect_arb
  import if_fetch_ctrl_pkg::*;
(
  input  logic [JbrBusW-1:0] jbr_bus_i,
  input  logic [ExcBusW-1:0] exc_bus_i,
  output logic               redir_o,
  output logic [RegW-1:0]    tgt_o,
  output logic               is_exc_o
);

  logic w_exc_v;
  logic w_jbr_v;

  assign w_exc_v  = exc_bus_i[ExcBusW-1];
  assign w_jbr_v  = jbr_bus_i[JbrBusW-1];
  assign redir_o  = w_exc_v | w_jbr_v;
  assign is_exc_o = w_exc_v;
  assign tgt_o    = w_exc_v ? exc_bus_i[RegW-1:0] : jbr_bus_i[RegW-1:0];

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, drives the instruction SRAM handshake
// (one request outstanding), cancels wrong-path fetches and holds a one-entry slot for ID.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [JbrBusW-1:0]  jbr_bus_i,
  input  logic [ExcBusW-1:0]  exc_bus_i,
  output logic                inst_sram_req_o,
  output logic [RegW-1:0]     inst_sram_addr_o,
  input  logic                inst_sram_addr_ok_i,
  input  logic                inst_sram_data_ok_i,
  input  logic [RegW-1:0]     inst_sram_rdata_i,
  output logic                if_valid_o,
  output logic [RegW-1:0]     if_pc_o,
  output logic [RegW-1:0]     if_inst_o,
  input  logic                id_allow_in_i
);

  fetch_state_e    r_state, w_state_nxt;
  logic [RegW-1:0] r_fpc, w_fpc_nxt;
  logic            r_pend_v, w_pend_v_nxt;
  logic [RegW-1:0] r_pend_tgt, w_pend_tgt_nxt;
  logic            r_pend_exc, w_pend_exc_nxt;
  logic            r_discard, w_discard_nxt;
  logic [RegW-1:0] r_inflight_pc, w_inflight_pc_nxt;
  logic            r_slot_v, w_slot_v_nxt;
  logic [RegW-1:0] r_slot_pc, w_slot_pc_nxt;
  logic [RegW-1:0] r_slot_inst, w_slot_inst_nxt;

  logic            w_redir;
  logic [RegW-1:0] w_tgt;
  logic            w_is_exc;
  logic            w_can_issue;
  logic            w_load;

  if_redirect_arb u_arb (
    .jbr_bus_i (jbr_bus_i),
    .exc_bus_i (exc_bus_i),
    .redir_o   (w_redir),
    .tgt_o     (w_tgt),
    .is_exc_o  (w_is_exc)
  );

  assign w_can_issue      = ~r_slot_v | id_allow_in_i;
  assign inst_sram_req_o  = (r_state == StReq);
  assign inst_sram_addr_o = r_fpc;
  assign if_valid_o       = r_slot_v & ~w_redir;
  assign if_pc_o          = r_slot_pc;
  assign if_inst_o        = r_slot_inst;

  always_comb begin
    w_state_nxt       = r_state;
    w_fpc_nxt         = r_fpc;
    w_pend_v_nxt      = r_pend_v;
    w_pend_tgt_nxt    = r_pend_tgt;
    w_pend_exc_nxt    = r_pend_exc;
    w_discard_nxt     = r_discard;
    w_inflight_pc_nxt = r_inflight_pc;
    w_load            = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_redir) w_fpc_nxt = w_tgt;
        if (w_can_issue) w_state_nxt = StReq;
      end
      StReq: begin
        if (inst_sram_addr_ok_i) begin
          w_state_nxt       = StWait;
          w_inflight_pc_nxt = r_fpc;
          if (w_redir || r_pend_v) begin
            w_discard_nxt = 1'b1;
            w_fpc_nxt     = w_redir ? w_tgt : r_pend_tgt;
            w_pend_v_nxt  = 1'b0;
          end else begin
            w_discard_nxt = 1'b0;
            w_fpc_nxt     = next_seq_pc(r_fpc);
          end
        end else if (w_redir) begin
          w_pend_v_nxt = 1'b1;
          // A pending exception target is never displaced by a later branch.
          if (!r_pend_v || w_is_exc || !r_pend_exc) begin
            w_pend_tgt_nxt = w_tgt;
            w_pend_exc_nxt = w_is_exc;
          end
        end
      end
      StWait: begin
        if (w_redir) begin
          w_discard_nxt = 1'b1;
          w_fpc_nxt     = w_tgt;
        end
        if (inst_sram_data_ok_i) begin
          w_state_nxt = StIdle;
          w_load      = ~r_discard & ~w_redir;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_slot_v_nxt    = r_slot_v;
    w_slot_pc_nxt   = r_slot_pc;
    w_slot_inst_nxt = r_slot_inst;
    if (w_redir || (if_valid_o && id_allow_in_i)) w_slot_v_nxt = 1'b0;
    if (w_load) begin
      w_slot_v_nxt    = 1'b1;
      w_slot_pc_nxt   = r_inflight_pc;
      w_slot_inst_nxt = inst_sram_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= StIdle;
      r_fpc         <= LoongPcStartAddr;
      r_pend_v      <= 1'b0;
      r_pend_tgt    <= '0;
      r_pend_exc    <= 1'b0;
      r_discard     <= 1'b0;
      r_inflight_pc <= '0;
      r_slot_v      <= 1'b0;
      r_slot_pc     <= '0;
      r_slot_inst   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fpc         <= w_fpc_nxt;
      r_pend_v      <= w_pend_v_nxt;
      r_pend_tgt    <= w_pend_tgt_nxt;
      r_pend_exc    <= w_pend_exc_nxt;
      r_discard     <= w_discard_nxt;
      r_inflight_pc <= w_inflight_pc_nxt;
      r_slot_v      <= w_slot_v_nxt;
      r_slot_pc     <= w_slot_pc_nxt;
      r_slot_inst   <= w_slot_inst_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios then random traffic, all
// checked against a transaction-level model of fetch order, kills and the ID slot.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [32:0] jbr, exc;
  logic        addr_ok, data_ok, allow;
  logic [31:0] rdata;
  logic        req, vld;
  logic [31:0] addr, pc, inst;

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .jbr_bus_i           (jbr),
    .exc_bus_i           (exc),
    .inst_sram_req_o     (req),
    .inst_sram_addr_o    (addr),
    .inst_sram_addr_ok_i (addr_ok),
    .inst_sram_data_ok_i (data_ok),
    .inst_sram_rdata_i   (rdata),
    .if_valid_o          (vld),
    .if_pc_o             (pc),
    .if_inst_o           (inst),
    .id_allow_in_i       (allow)
  );

  int total = 0;
  int bad   = 0;

  // Model: next fetch address, request window, one outstanding read, one slot.
  logic        m_slot_v;
  logic [31:0] m_slot_pc, m_slot_inst;
  logic [31:0] m_nxt, m_req_addr, m_out_pc, m_win_tgt;
  logic        m_inreq, m_out, m_wrong, m_req_exp, m_win_v, m_win_exc;
  int          m_loads;
  logic [31:0] q_acc[$];
  logic [31:0] saved_pc, saved_inst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_slot_v = 1'b0; m_slot_pc = '0; m_slot_inst = '0;
    m_nxt = 32'h1c000000; m_req_addr = '0; m_out_pc = '0; m_win_tgt = '0;
    m_inreq = 1'b0; m_out = 1'b0; m_wrong = 1'b0; m_req_exp = 1'b0;
    m_win_v = 1'b0; m_win_exc = 1'b0; m_loads = 0;
    q_acc.delete();
  endtask

  task automatic idle_inputs();
    jbr = '0; exc = '0; addr_ok = 1'b0; data_ok = 1'b0; allow = 1'b1; rdata = '0;
  endtask

  // Called just after a posedge; applies reset and returns just after a posedge.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk1("rst_req", req, 1'b0);
    chk("rst_addr", addr, 32'h1c000000);
    chk1("rst_valid", vld, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic cyc();
    logic        redir, isexc, can, idle, nreq;
    logic [31:0] tgt;
    @(negedge clk);
    isexc = exc[32];
    redir = exc[32] | jbr[32];
    tgt   = isexc ? exc[31:0] : jbr[31:0];
    chk1("req", req, m_req_exp);
    if (m_req_exp) begin
      if (!m_inreq) begin
        chk("req_addr", addr, m_nxt);
        m_inreq = 1'b1; m_req_addr = m_nxt; m_win_v = 1'b0;
      end else begin
        chk("addr_hold", addr, m_req_addr);
      end
    end
    if (req && addr_ok) q_acc.push_back(addr);
    chk1("if_valid", vld, m_slot_v & ~redir);
    if (m_slot_v && !redir) begin
      chk("if_pc", pc, m_slot_pc);
      chk("if_inst", inst, m_slot_inst);
    end
    can  = ~m_slot_v | allow;
    idle = ~m_req_exp & ~m_out;
    if (redir || allow) m_slot_v = 1'b0;
    if (m_out) begin
      if (redir) begin m_wrong = 1'b1; m_nxt = tgt; end
      if (data_ok) begin
        if (!m_wrong) begin
          m_slot_v = 1'b1; m_slot_pc = m_out_pc; m_slot_inst = rdata; m_loads++;
        end
        m_out = 1'b0;
      end
    end
    if (m_req_exp) begin
      if (addr_ok) begin
        m_out = 1'b1; m_out_pc = m_req_addr; m_wrong = redir | m_win_v;
        m_nxt = redir ? tgt : (m_win_v ? m_win_tgt : m_req_addr + 32'd4);
        m_inreq = 1'b0;
      end else if (redir) begin
        if (!m_win_v || isexc || !m_win_exc) begin m_win_tgt = tgt; m_win_exc = isexc; end
        m_win_v = 1'b1;
      end
    end
    if (idle && redir) m_nxt = tgt;
    nreq = (m_req_exp & ~addr_ok) | (idle & can);
    m_req_exp = nreq;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;

    // Zero-wait streaming from the reset address.
    do_reset();
    addr_ok = 1'b1; data_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin rdata = $urandom; cyc(); end
    chk("stream0", q_acc[0], 32'h1c000000);
    chk("stream1", q_acc[1], 32'h1c000004);
    chk("stream2", q_acc[2], 32'h1c000008);

    // Branch while fetch of 0x1c000004 is outstanding: data dropped, redirect taken.
    do_reset();
    addr_ok = 1'b1; data_ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      jbr = (m_out && m_out_pc == 32'h1c000004) ? {1'b1, 32'h1c000100} : 33'd0;
      rdata = $urandom;
      cyc();
    end
    jbr = '0;
    chk("br_wait", q_acc[2], 32'h1c000100);

    // Simultaneous exception and branch in IDLE: exception wins.
    do_reset();
    addr_ok = 1'b1; data_ok = 1'b1;
    exc = {1'b1, 32'h1c008000}; jbr = {1'b1, 32'h1c000200};
    cyc();
    exc = '0; jbr = '0;
    for (int i = 0; i < 3; i++) cyc();
    chk("exc_prio", q_acc[0], 32'h1c008000);

    // addr_ok held off three cycles with a branch on the first request cycle.
    do_reset();
    addr_ok = 1'b0; data_ok = 1'b1;
    cyc();
    jbr = {1'b1, 32'h1c000040};
    cyc();
    jbr = '0;
    cyc(); cyc();
    addr_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin rdata = $urandom; cyc(); end
    chk("stall_addr", q_acc[0], 32'h1c000000);
    chk("stall_redir", q_acc[1], 32'h1c000040);

    // Full slot with ID stalled: no new request until allow_in returns.
    do_reset();
    addr_ok = 1'b1; data_ok = 1'b1; allow = 1'b0;
    for (int i = 0; i < 3; i++) begin rdata = $urandom; cyc(); end
    chk1("slot_full", m_slot_v, 1'b1);
    saved_pc = m_slot_pc; saved_inst = m_slot_inst;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk1("hold_noreq", req, 1'b0);
      chk("hold_pc", pc, saved_pc);
      chk("hold_inst", inst, saved_inst);
    end
    allow = 1'b1;
    cyc();
    chk1("resume_req", req, 1'b1);
    for (int i = 0; i < 3; i++) cyc();
    chk("resume_addr", q_acc[1], 32'h1c000004);

    // Reset during WAIT, then a stale data_ok right after release.
    do_reset();
    addr_ok = 1'b1; data_ok = 1'b0;
    for (int i = 0; i < 8 && !m_out; i++) cyc();
    chk1("reach_wait", m_out, 1'b1);
    do_reset();
    data_ok = 1'b1; addr_ok = 1'b0; rdata = 32'hdeadbeef;
    cyc();
    chk1("stale_valid", vld, 1'b0);
    addr_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin rdata = $urandom; cyc(); end
    chk("restart", q_acc[0], 32'h1c000000);

    // Random traffic: redirects, SRAM latency and ID back-pressure.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      exc     = {($urandom_range(0, 99) < 4), 32'($urandom)};
      jbr     = {($urandom_range(0, 99) < 10), 32'($urandom)};
      addr_ok = ($urandom_range(0, 9) < 6);
      data_ok = ($urandom_range(0, 9) < 5);
      allow   = ($urandom_range(0, 9) < 7);
      rdata   = $urandom;
      cyc();
    end
    chk1("liveness", (m_loads > 50), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
